wordcount_top: RTL and testbench
================================

# wordcount_top

Word-count engine between a host-programmed control register block and a pair of AXI-stream DMA masters (one read master, one write master). The host kicks a command with scalar parameters. The block then does one of three things: clears its internal 16-entry key/count table, streams 32-bit words from global memory and counts occurrences of each distinct word, or writes the table back to global memory.

## Interface
- No parameters. Fixed values: 16 table entries, 32-bit words, 512-bit stream beats.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- kick  in  1  command strobe; sampled only while idle.
- busy  out  1  high while a command executes.
- command  in  32  command code: 1=CLEAR, 2=COUNT, 3=WRITEBACK, any other value=NOP.
- num_of_words  in  32  number of 32-bit words to count (COUNT only).
- global_memory_offset  in  64  byte address used for the read (COUNT) or the write (WRITEBACK).
- reader_ctrl_start  out  1  one-cycle pulse that starts a read transfer.
- reader_ctrl_done  in  1  read master completion pulse.
- reader_ctrl_addr_offset  out  64  read start address.
- reader_ctrl_xfer_size_in_bytes  out  64  read length in bytes.
- reader_s_axis_tvalid / tready / tdata / tlast  in / out / in(512) / in  read data stream; the block is the sink.
- writer_ctrl_start  out  1  one-cycle pulse that starts a write transfer.
- writer_ctrl_done  in  1  write master completion pulse.
- writer_ctrl_addr_offset  out  64  write start address.
- writer_ctrl_xfer_size_in_bytes  out  64  write length; always 128.
- writer_m_axis_tvalid / tready / tdata  out / in / out(512)  write data stream; the block is the source.

## Operation
- Table: 16 entries, each holding {valid, key[31:0], count[31:0]}.
- Latching: on kick while idle, the block latches command, num_of_words and global_memory_offset, and busy rises the next cycle. Kick while busy is ignored.
- States: IDLE, CLEAR, RD_START, RD_DATA, RD_WAIT, WR_START, WR_DATA, WR_WAIT.
- CLEAR (command 1): clears every valid bit and count in one cycle, then returns to IDLE.
- NOP (unknown command): one busy cycle, then IDLE.
- COUNT (command 2), read setup:
  - If N=num_of_words is 0, return to IDLE immediately without starting a read.
  - Otherwise assert reader_ctrl_start for one cycle with addr=offset and xfer_size = ceil(4N/64)*64.
- COUNT, data processing:
  - Each beat carries 16 words; word i = tdata[32i+31:32i], processed lowest index first, one word per cycle.
  - tready is asserted only on the cycle the last needed word of the current beat is consumed.
  - Words past N in the final beat are ignored. tlast is ignored; the block counts words itself.
- COUNT, per-word update:
  - Word matches a valid entry: that entry's count += 1, saturating at 0xFFFFFFFF.
  - No match: the word is written to the lowest-index invalid entry with count=1.
  - No match and table full: the word is dropped.
- COUNT, completion: after N words are consumed, the block waits in RD_WAIT until reader_ctrl_done has been seen. A done pulse arriving earlier is latched.
- WRITEBACK (command 3), write setup: assert writer_ctrl_start for one cycle with addr=offset and size=128.
- WRITEBACK, data beats:
  - Beat 0 holds entries 0–7 and beat 1 holds entries 8–15. Entry k sits at bits [64j+63:64j], j=k mod 8, as {count, key}.
  - Invalid entries are sent as all zeros.
  - tvalid is held with tdata stable until tready.
- WRITEBACK, completion: wait for writer_ctrl_done (latched if early), then IDLE.
- The table persists across commands until CLEAR or reset.

## Timing
- Reset values: busy, both start pulses and writer tvalid are 0; all address, size and tdata outputs are 0; the table is cleared; reader tready is 0.
- busy: high from the cycle after kick up to and including the final state cycle. The cycle busy is low, a new kick is accepted.
- Start pulses: issued the cycle after busy rises; address and size are valid on the same cycle and held until the next command.
- COUNT throughput is 1 word/clk while tvalid is high. A full 128-word COUNT takes ≥128 data cycles plus overhead.
- Saturation: a matching word on a saturated count leaves the count at 0xFFFFFFFF.
- Reset mid-operation aborts immediately and returns to IDLE; in-flight stream beats are not acknowledged.

## Test plan
- Reset, then CLEAR: busy rises for 1 cycle then falls; both start pulses stay 0.
- COUNT N=128 at 0x80000000; every beat's 16 words = {0x11c0ffee×4, 0xabadcafe×4, 0xdeadbeef×4, 0x89abcdef, 0x01234567, 0x89abcdef, 0x01234567} from the low word up:
  - Read request: start with size 512.
  - Exactly 8 tready pulses.
  - Table: 0x11c0ffee/0xabadcafe/0xdeadbeef=32 each, 0x89abcdef/0x01234567=16 each.
  - busy falls after reader_ctrl_done.
- WRITEBACK after that COUNT: start, addr 0x80000000, size 128. Beat 0 entry 0 = {32, 0x11c0ffee}; entries 5–15 zero. Holding tready low stalls the beat.
- Table-full test: 20 distinct words → 16 entries count 1, the remaining 4 are dropped.
- COUNT N=5: read size 64; one beat; words 5–15 ignored.
- Kick while busy is ignored. Unknown command 7: busy for 1 cycle, no start pulse. reader_ctrl_done arriving before the last word still completes.

Source files
------------

// File: rtl/wordcount_top.sv
// wordcount_top
//   Word-count engine sitting between a host control block and a pair of
//   AXI-stream DMA masters. A kicked command either clears the 16-entry
//   key/count table, streams 32-bit words from memory and counts each
//   distinct word, or writes the table back to memory as two 512-bit beats.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   kick / busy                     command strobe (sampled while idle) / busy flag
//   command, num_of_words,
//   global_memory_offset            command code (1 clear, 2 count, 3 writeback),
//                                   word count, byte address
//   reader_ctrl_*                   read-master start pulse, done pulse, addr, size
//   reader_s_axis_*                 512-bit read stream, this block is the sink
//   writer_ctrl_*                   write-master start pulse, done pulse, addr, size
//   writer_m_axis_*                 512-bit write stream, this block is the source
module wordcount_top (
    input  logic         clk,
    input  logic         reset,
    input  logic         kick,
    output logic         busy,
    input  logic [31:0]  command,
    input  logic [31:0]  num_of_words,
    input  logic [63:0]  global_memory_offset,
    output logic         reader_ctrl_start,
    input  logic         reader_ctrl_done,
    output logic [63:0]  reader_ctrl_addr_offset,
    output logic [63:0]  reader_ctrl_xfer_size_in_bytes,
    input  logic         reader_s_axis_tvalid,
    output logic         reader_s_axis_tready,
    input  logic [511:0] reader_s_axis_tdata,
    input  logic         reader_s_axis_tlast,
    output logic         writer_ctrl_start,
    input  logic         writer_ctrl_done,
    output logic [63:0]  writer_ctrl_addr_offset,
    output logic [63:0]  writer_ctrl_xfer_size_in_bytes,
    output logic         writer_m_axis_tvalid,
    input  logic         writer_m_axis_tready,
    output logic [511:0] writer_m_axis_tdata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_NOP,
        S_RD_START,
        S_RD_DATA,
        S_RD_WAIT,
        S_WR_START,
        S_WR_DATA,
        S_WR_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_num;
    logic [63:0] r_offset;
    logic [31:0] r_remaining;
    logic [3:0]  r_word_idx;
    logic        r_wr_beat;
    logic        r_rd_done_seen;
    logic        r_wr_done_seen;

    logic [15:0] r_valid;
    logic [31:0] r_key   [16];
    logic [31:0] r_count [16];

    logic        r_rd_start;
    logic        r_wr_start;
    logic [63:0] r_rd_addr;
    logic [63:0] r_rd_size;
    logic [63:0] r_wr_addr;
    logic [63:0] r_wr_size;

    logic [31:0] w_word;
    logic        w_take;
    logic        w_last_in_beat;
    logic        w_hit;
    logic [3:0]  w_hit_idx;
    logic        w_free_avail;
    logic [3:0]  w_free_idx;
    logic [32:0] w_n_round;
    logic [63:0] w_rd_size;
    logic [511:0] w_wr_data;

    // The stream marks its own end, but the word counter is authoritative.
    logic w_unused;
    assign w_unused = &{1'b0, reader_s_axis_tlast};

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Current word of the beat, lowest lane first.
    assign w_word         = reader_s_axis_tdata[{r_word_idx, 5'b0} +: 32];
    assign w_take         = (r_state == S_RD_DATA) && reader_s_axis_tvalid;
    // A beat is released when lane 15 or the final requested word is consumed.
    assign w_last_in_beat = (r_word_idx == 4'd15) || (r_remaining == 32'd1);

    // ceil(N/16) beats of 64 bytes each.
    assign w_n_round = {1'b0, r_num} + 33'd15;
    assign w_rd_size = {29'b0, w_n_round[32:4], 6'b0};

    // Lookup: the descending loop leaves the lowest matching / free index.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = 4'd0;
        w_free_avail = 1'b0;
        w_free_idx   = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (r_valid[k] && (r_key[k] == w_word)) begin
                w_hit     = 1'b1;
                w_hit_idx = 4'(k);
            end
            if (!r_valid[k]) begin
                w_free_avail = 1'b1;
                w_free_idx   = 4'(k);
            end
        end
    end

    // Writeback beat: entries {beat,j} packed as {count, key}, invalid as zero.
    always_comb begin
        w_wr_data = '0;
        if (r_state == S_WR_DATA) begin
            for (int j = 0; j < 8; j++) begin
                if (r_valid[{r_wr_beat, 3'(j)}]) begin
                    w_wr_data[64*j +: 64] = {r_count[{r_wr_beat, 3'(j)}], r_key[{r_wr_beat, 3'(j)}]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (kick) begin
                    case (command)
                        32'd1:   w_next = S_CLEAR;
                        32'd2:   w_next = S_RD_START;
                        32'd3:   w_next = S_WR_START;
                        default: w_next = S_NOP;
                    endcase
                end
            end
            S_CLEAR:    w_next = S_IDLE;
            S_NOP:      w_next = S_IDLE;
            S_RD_START: w_next = (r_num == 32'd0) ? S_IDLE : S_RD_DATA;
            S_RD_DATA: begin
                if (w_take && (r_remaining == 32'd1)) begin
                    w_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_rd_done_seen || reader_ctrl_done) begin
                    w_next = S_IDLE;
                end
            end
            S_WR_START: w_next = S_WR_DATA;
            S_WR_DATA: begin
                if (writer_m_axis_tready && r_wr_beat) begin
                    w_next = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (r_wr_done_seen || writer_ctrl_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num          <= '0;
            r_offset       <= '0;
            r_remaining    <= '0;
            r_word_idx     <= '0;
            r_wr_beat      <= 1'b0;
            r_rd_done_seen <= 1'b0;
            r_wr_done_seen <= 1'b0;
            r_valid        <= '0;
            r_rd_start     <= 1'b0;
            r_wr_start     <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_size      <= '0;
            r_wr_addr      <= '0;
            r_wr_size      <= '0;
            for (int k = 0; k < 16; k++) begin
                r_key[k]   <= '0;
                r_count[k] <= '0;
            end
        end else begin
            r_rd_start <= 1'b0;
            r_wr_start <= 1'b0;

            if ((r_state == S_IDLE) && kick) begin
                r_num          <= num_of_words;
                r_offset       <= global_memory_offset;
                r_rd_done_seen <= 1'b0;
                r_wr_done_seen <= 1'b0;
            end

            // Done pulses may beat the last data word; remember them.
            if (reader_ctrl_done && ((r_state == S_RD_START) || (r_state == S_RD_DATA) ||
                                     (r_state == S_RD_WAIT))) begin
                r_rd_done_seen <= 1'b1;
            end
            if (writer_ctrl_done && ((r_state == S_WR_START) || (r_state == S_WR_DATA) ||
                                     (r_state == S_WR_WAIT))) begin
                r_wr_done_seen <= 1'b1;
            end

            if (r_state == S_CLEAR) begin
                r_valid <= '0;
                for (int k = 0; k < 16; k++) begin
                    r_count[k] <= '0;
                end
            end

            if (r_state == S_RD_START) begin
                r_remaining <= r_num;
                r_word_idx  <= '0;
                if (r_num != 32'd0) begin
                    r_rd_start <= 1'b1;
                    r_rd_addr  <= r_offset;
                    r_rd_size  <= w_rd_size;
                end
            end

            if (w_take) begin
                r_remaining <= r_remaining - 32'd1;
                r_word_idx  <= w_last_in_beat ? 4'd0 : r_word_idx + 4'd1;
                if (w_hit) begin
                    r_count[w_hit_idx] <= sat_inc(r_count[w_hit_idx]);
                end else if (w_free_avail) begin
                    r_valid[w_free_idx] <= 1'b1;
                    r_key[w_free_idx]   <= w_word;
                    r_count[w_free_idx] <= 32'd1;
                end
            end

            if (r_state == S_WR_START) begin
                r_wr_start <= 1'b1;
                r_wr_addr  <= r_offset;
                r_wr_size  <= 64'd128;
                r_wr_beat  <= 1'b0;
            end

            if ((r_state == S_WR_DATA) && writer_m_axis_tready) begin
                r_wr_beat <= 1'b1;
            end
        end
    end

    assign busy                           = (r_state != S_IDLE);
    assign reader_ctrl_start              = r_rd_start;
    assign reader_ctrl_addr_offset        = r_rd_addr;
    assign reader_ctrl_xfer_size_in_bytes = r_rd_size;
    assign reader_s_axis_tready           = w_take && w_last_in_beat;
    assign writer_ctrl_start              = r_wr_start;
    assign writer_ctrl_addr_offset        = r_wr_addr;
    assign writer_ctrl_xfer_size_in_bytes = r_wr_size;
    assign writer_m_axis_tvalid           = (r_state == S_WR_DATA);
    assign writer_m_axis_tdata            = w_wr_data;

endmodule

// File: tb/tb_wordcount_top.sv
module tb_wordcount_top;

    logic         clk = 1'b0;
    logic         reset;
    logic         kick;
    logic         busy;
    logic [31:0]  command;
    logic [31:0]  num_of_words;
    logic [63:0]  global_memory_offset;
    logic         reader_ctrl_start;
    logic         reader_ctrl_done;
    logic [63:0]  reader_ctrl_addr_offset;
    logic [63:0]  reader_ctrl_xfer_size_in_bytes;
    logic         reader_s_axis_tvalid;
    logic         reader_s_axis_tready;
    logic [511:0] reader_s_axis_tdata;
    logic         reader_s_axis_tlast;
    logic         writer_ctrl_start;
    logic         writer_ctrl_done;
    logic [63:0]  writer_ctrl_addr_offset;
    logic [63:0]  writer_ctrl_xfer_size_in_bytes;
    logic         writer_m_axis_tvalid;
    logic         writer_m_axis_tready;
    logic [511:0] writer_m_axis_tdata;

    wordcount_top dut (
        .clk                            (clk),
        .reset                          (reset),
        .kick                           (kick),
        .busy                           (busy),
        .command                        (command),
        .num_of_words                   (num_of_words),
        .global_memory_offset           (global_memory_offset),
        .reader_ctrl_start              (reader_ctrl_start),
        .reader_ctrl_done               (reader_ctrl_done),
        .reader_ctrl_addr_offset        (reader_ctrl_addr_offset),
        .reader_ctrl_xfer_size_in_bytes (reader_ctrl_xfer_size_in_bytes),
        .reader_s_axis_tvalid           (reader_s_axis_tvalid),
        .reader_s_axis_tready           (reader_s_axis_tready),
        .reader_s_axis_tdata            (reader_s_axis_tdata),
        .reader_s_axis_tlast            (reader_s_axis_tlast),
        .writer_ctrl_start              (writer_ctrl_start),
        .writer_ctrl_done               (writer_ctrl_done),
        .writer_ctrl_addr_offset        (writer_ctrl_addr_offset),
        .writer_ctrl_xfer_size_in_bytes (writer_ctrl_xfer_size_in_bytes),
        .writer_m_axis_tvalid           (writer_m_axis_tvalid),
        .writer_m_axis_tready           (writer_m_axis_tready),
        .writer_m_axis_tdata            (writer_m_axis_tdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rdy_cnt = 0;
    int rds_cnt = 0;
    int wrs_cnt = 0;

    logic [511:0] beats [16];
    logic [511:0] exp_q [$];
    logic [63:0]  exp_e [16];

    always @(negedge clk) begin
        if (reader_s_axis_tready) rdy_cnt++;
        if (reader_ctrl_start)    rds_cnt++;
        if (writer_ctrl_start)    wrs_cnt++;
    end

    function automatic logic [511:0] mk_beat(input logic [31:0] w [16]);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = w[i];
        return b;
    endfunction

    // Expected writeback beats go to the scoreboard when the command is issued.
    task automatic push_wb();
        logic [511:0] b;
        for (int h = 0; h < 2; h++) begin
            for (int j = 0; j < 8; j++) b[64*j +: 64] = exp_e[8*h + j];
            exp_q.push_back(b);
        end
    endtask

    task automatic do_kick(input logic [31:0] cmd, input logic [31:0] n, input logic [63:0] off);
        @(posedge clk); #1;
        command = cmd; num_of_words = n; global_memory_offset = off; kick = 1'b1;
        @(posedge clk); #1;
        kick = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s busy_timeout got=1 exp=0", name); end
    endtask

    task automatic wait_start(input bit wr, input logic [63:0] a, input logic [63:0] sz);
        bit seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (wr ? writer_ctrl_start : reader_ctrl_start) begin
                seen = 1;
                total++;
                if ((wr ? writer_ctrl_addr_offset : reader_ctrl_addr_offset) !== a) begin
                    bad++;
                    $display("FAIL start_addr(wr=%0d) got=%h exp=%h", wr,
                             wr ? writer_ctrl_addr_offset : reader_ctrl_addr_offset, a);
                end
                total++;
                if ((wr ? writer_ctrl_xfer_size_in_bytes : reader_ctrl_xfer_size_in_bytes) !== sz) begin
                    bad++;
                    $display("FAIL start_size(wr=%0d) got=%0d exp=%0d", wr,
                             wr ? writer_ctrl_xfer_size_in_bytes : reader_ctrl_xfer_size_in_bytes, sz);
                end
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL start_timeout(wr=%0d) got=0 exp=1", wr); end
    endtask

    task automatic serve_beats(input int nb);
        bit got;
        for (int b = 0; b < nb; b++) begin
            @(posedge clk); #1;
            reader_s_axis_tdata  = beats[b];
            reader_s_axis_tvalid = 1'b1;
            reader_s_axis_tlast  = (b == nb - 1);
            got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (reader_s_axis_tready) got = 1;
                else begin @(posedge clk); #1; end
            end
            if (!got) begin
                total++; bad++;
                $display("FAIL beat_tready_timeout beat=%0d got=0 exp=1", b);
                break;
            end
        end
        @(posedge clk); #1;
        reader_s_axis_tvalid = 1'b0;
        reader_s_axis_tlast  = 1'b0;
    endtask

    task automatic finish_read(input bit send_done, input int rdy0, input int exp_rdy);
        if (send_done) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL busy_before_done got=%b exp=1", busy); end
            end
            @(posedge clk); #1; reader_ctrl_done = 1'b1;
            @(posedge clk); #1; reader_ctrl_done = 1'b0;
        end
        wait_idle("read_done");
        @(posedge clk); #1;
        total++;
        if (rdy_cnt - rdy0 !== exp_rdy) begin
            bad++; $display("FAIL tready_pulses got=%0d exp=%0d", rdy_cnt - rdy0, exp_rdy);
        end
    endtask

    task automatic recv_wb(input logic [63:0] a, input bit stall, input bit kick_busy);
        int got = 0;
        logic [511:0] e;
        wait_start(1'b1, a, 64'd128);
        if (stall) begin
            writer_m_axis_tready = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                total++;
                if (writer_m_axis_tvalid !== 1'b1 || writer_m_axis_tdata !== exp_q[0]) begin
                    bad++;
                    $display("FAIL wb_stall valid=%b data=%h exp=%h", writer_m_axis_tvalid,
                             writer_m_axis_tdata[127:0], exp_q[0][127:0]);
                end
            end
        end
        @(posedge clk); #1;
        writer_m_axis_tready = 1'b1;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (writer_m_axis_tvalid && writer_m_axis_tready) begin
                e = exp_q.pop_front();
                got++;
                total++;
                if (writer_m_axis_tdata !== e) begin
                    bad++;
                    $display("FAIL wb_beat%0d got=%h exp=%h", got - 1, writer_m_axis_tdata, e);
                end
            end
        end
        total++;
        if (got != 2) begin bad++; $display("FAIL wb_beat_timeout got=%0d exp=2", got); end
        @(posedge clk); #1;
        writer_m_axis_tready = 1'b0;
        @(negedge clk);
        total++;
        if (writer_m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL wb_wait valid=%b busy=%b exp valid=0 busy=1", writer_m_axis_tvalid, busy);
        end
        if (kick_busy) begin
            @(posedge clk); #1; command = 32'd1; kick = 1'b1;
            @(posedge clk); #1; kick = 1'b0;
        end
        @(posedge clk); #1; writer_ctrl_done = 1'b1;
        @(posedge clk); #1; writer_ctrl_done = 1'b0;
        wait_idle("wb_done");
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_wb got=%b exp=0", busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 0 || reader_ctrl_start !== 0 || writer_ctrl_start !== 0 || writer_m_axis_tvalid !== 0 ||
            reader_s_axis_tready !== 0) begin
            bad++; $display("FAIL reset_ctrl busy=%b rs=%b ws=%b wv=%b rr=%b exp all 0", busy,
                            reader_ctrl_start, writer_ctrl_start, writer_m_axis_tvalid, reader_s_axis_tready);
        end
        total++;
        if (reader_ctrl_addr_offset !== 0 || reader_ctrl_xfer_size_in_bytes !== 0 ||
            writer_ctrl_addr_offset !== 0 || writer_ctrl_xfer_size_in_bytes !== 0 || writer_m_axis_tdata !== 0) begin
            bad++; $display("FAIL reset_data addr/size/tdata nonzero exp=0");
        end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_clear();
        int r0 = rds_cnt, w0 = wrs_cnt;
        do_kick(32'd1, 32'd0, 64'd0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy_high got=%b exp=1", busy); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy_low got=%b exp=0", busy); end
        @(posedge clk); #1;
        total++;
        if (rds_cnt != r0 || wrs_cnt != w0) begin
            bad++; $display("FAIL clear_starts got=%0d/%0d exp=0/0", rds_cnt - r0, wrs_cnt - w0);
        end
    endtask

    task automatic test_count128();
        logic [31:0] w [16];
        int r0;
        for (int i = 0; i < 4; i++) begin
            w[i] = 32'h11c0ffee; w[4+i] = 32'habadcafe; w[8+i] = 32'hdeadbeef;
        end
        w[12] = 32'h89abcdef; w[13] = 32'h01234567; w[14] = 32'h89abcdef; w[15] = 32'h01234567;
        for (int b = 0; b < 8; b++) beats[b] = mk_beat(w);
        r0 = rdy_cnt;
        do_kick(32'd2, 32'd128, 64'h8000_0000);
        wait_start(1'b0, 64'h8000_0000, 64'd512);
        serve_beats(8);
        finish_read(1'b1, r0, 8);
    endtask

    task automatic test_writeback();
        for (int k = 0; k < 16; k++) exp_e[k] = 64'd0;
        exp_e[0] = {32'd32, 32'h11c0ffee};
        exp_e[1] = {32'd32, 32'habadcafe};
        exp_e[2] = {32'd32, 32'hdeadbeef};
        exp_e[3] = {32'd16, 32'h89abcdef};
        exp_e[4] = {32'd16, 32'h01234567};
        push_wb();
        do_kick(32'd3, 32'd0, 64'h8000_0000);
        recv_wb(64'h8000_0000, 1'b1, 1'b1);
        // The CLEAR kicked while busy must not have taken effect.
        push_wb();
        do_kick(32'd3, 32'd0, 64'h1000);
        recv_wb(64'h1000, 1'b0, 1'b0);
    endtask

    task automatic test_nop();
        int r0 = rds_cnt, w0 = wrs_cnt;
        do_kick(32'd7, 32'd4, 64'h40);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL nop_busy_high got=%b exp=1", busy); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL nop_busy_low got=%b exp=0", busy); end
        @(posedge clk); #1;
        total++;
        if (rds_cnt != r0 || wrs_cnt != w0) begin
            bad++; $display("FAIL nop_starts got=%0d/%0d exp=0/0", rds_cnt - r0, wrs_cnt - w0);
        end
    endtask

    task automatic test_table_full();
        logic [31:0] w [16];
        int r0;
        do_kick(32'd1, 32'd0, 64'd0);
        wait_idle("clear_full");
        for (int i = 0; i < 16; i++) w[i] = 32'h1000 + i;
        beats[0] = mk_beat(w);
        for (int i = 0; i < 16; i++) w[i] = (i < 4) ? 32'h1010 + i : 32'hF000 + i;
        beats[1] = mk_beat(w);
        r0 = rdy_cnt;
        do_kick(32'd2, 32'd20, 64'h2000);
        wait_start(1'b0, 64'h2000, 64'd128);
        serve_beats(2);
        finish_read(1'b1, r0, 2);
        for (int k = 0; k < 16; k++) exp_e[k] = {32'd1, 32'h1000 + k};
        push_wb();
        do_kick(32'd3, 32'd0, 64'h3000);
        recv_wb(64'h3000, 1'b0, 1'b0);
    endtask

    task automatic test_short_early_done();
        logic [31:0] w [16];
        int r0;
        do_kick(32'd1, 32'd0, 64'd0);
        wait_idle("clear_short");
        w[0] = 32'hAAAA0001; w[1] = 32'hBBBB0002; w[2] = 32'hAAAA0001;
        w[3] = 32'hCCCC0003; w[4] = 32'hAAAA0001;
        for (int i = 5; i < 16; i++) w[i] = 32'h7000 + i;
        beats[0] = mk_beat(w);
        r0 = rdy_cnt;
        do_kick(32'd2, 32'd5, 64'h4400);
        wait_start(1'b0, 64'h4400, 64'd64);
        @(posedge clk); #1; reader_ctrl_done = 1'b1;
        @(posedge clk); #1; reader_ctrl_done = 1'b0;
        serve_beats(1);
        finish_read(1'b0, r0, 1);
        for (int k = 0; k < 16; k++) exp_e[k] = 64'd0;
        exp_e[0] = {32'd3, 32'hAAAA0001};
        exp_e[1] = {32'd1, 32'hBBBB0002};
        exp_e[2] = {32'd1, 32'hCCCC0003};
        push_wb();
        do_kick(32'd3, 32'd0, 64'h5000);
        recv_wb(64'h5000, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; kick = 1'b0; command = '0; num_of_words = '0; global_memory_offset = '0;
        reader_ctrl_done = 1'b0; reader_s_axis_tvalid = 1'b0; reader_s_axis_tdata = '0;
        reader_s_axis_tlast = 1'b0; writer_ctrl_done = 1'b0; writer_m_axis_tready = 1'b0;
        test_reset();
        test_clear();
        test_count128();
        test_writeback();
        test_nop();
        test_table_full();
        test_short_early_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
